control_sequencer: RTL
======================

Name: control_sequencer

Overview:
- Hardwired Moore control unit that issues the per-cycle datapath strobes (PCout, MARin, IncPC, Zin, Read, MDRin, IRin, Gra, Rin, ...) consumed by the Datapath.
- It replaces bench-driven control sequencing with an on-chip fetch/decode/execute FSM.
- It sits beside Datapath, reads the instruction register contents, and drives every control input of Datapath except Clock.

Parameters:
- ALU_ADD, 4'd0: ALUop code for add (also used for ldi and PC-independent adds)
- ALU_SUB, 4'd1: ALUop code for sub
- ALU_AND, 4'd2: ALUop code for and
- ALU_OR, 4'd3: ALUop code for or
- ALU_MUL, 4'd4: ALUop code for mul
- ALU_DIV, 4'd5: ALUop code for div

Ports:
- Clock  in  1  system clock; all state changes on the rising edge
- Reset  in  1  synchronous, active-high reset
- IR  in  32  instruction register value; opcode is IR[31:27]
- Stop  in  1  halt request, sampled at the last step of each instruction
- Run  out  1  1 while the machine is executing, 0 in RESET/HALT
- PCout, Zlowout, Zhighout, MDRout, HIout, LOout, Cout, BAout, Rout  out  1 each  bus-drive enables
- MARin, Zin, PCin, MDRin, IRin, Yin, LOin, HIin, Rin, CONin  out  1 each  register load enables
- IncPC, Read, Write  out  1 each  PC increment and memory strobes
- Gra, Grb, Grc  out  1 each  register-field selects
- ALUop  out  4  ALU function select; ALU_ADD when no ALU operation is active

Behaviour:
- Clocking and reset:
  - One clock; Reset is synchronous and active-high. Reset forces state RST.
  - All outputs are a combinational decode of the state register and IR[31:27] only; no output depends on Stop.
  - Outputs are stable for the whole cycle, and Datapath samples them at the next rising edge.
- RST: all strobes 0, Run=0, ALUop=ALU_ADD. The next edge with Reset=0 moves to T0.
- Fetch (every instruction, each step 1 cycle):
  - T0: PCout, MARin, IncPC, Zin
  - T1: Zlowout, PCin, Read, MDRin
  - T2: MDRout, IRin
  - Latency: IR is valid from T3 onward.
- Decode at T3 on IR[31:27]:
  - 00011 add, 00100 sub, 00101 and, 00110 or:
    - T3: Grb, Rout, Yin
    - T4: Grc, Rout, Zin, ALUop=op
    - T5: Zlowout, Gra, Rin
  - 01110 mul, 01111 div:
    - T3: Gra, Rout, Yin
    - T4: Grb, Rout, Zin, ALUop=op
    - T5: Zlowout, LOin
    - T6: Zhighout, HIin
  - 00001 ldi:
    - T3: Grb, BAout, Yin
    - T4: Cout, Zin, ALUop=ALU_ADD
    - T5: Zlowout, Gra, Rin
  - 11000 mfhi: T3: HIout, Gra, Rin
  - 11001 mflo: T3: LOout, Gra, Rin
  - 11010 nop, and every unlisted opcode: T3 with all strobes 0
  - 11011 halt: T3 with all strobes 0, then unconditionally to HALT
- Last step of an instruction:
  - The last step is T5 for ALU/ldi, T6 for mul/div, and T3 for mfhi/mflo/nop/illegal.
  - If Stop=1 at that edge, go to HALT; otherwise go to T0.
- HALT: all strobes 0, Run=0. Held until Reset.
- Run=1 in every state except RST and HALT.
- Invariants:
  - Never more than one bus driver asserted in a cycle (PCout, Zlowout, Zhighout, MDRout, HIout, LOout, Cout, BAout, Rout are mutually exclusive).
  - At most one of Gra/Grb/Grc asserted in any cycle.
  - Write and CONin are always 0 in this revision; the ports are reserved for ld/st/branch.
- Reset mid-instruction: the next edge goes to RST regardless of state, with all strobes 0 in the following cycle. No partial register write occurs in the cycle after reset.
- Opcode is decoded from IR every cycle from T3 onward. IRin is asserted only in T2, so IR is stable through execute.

Test Plan:
- Reset then release: Reset=1 for 2 cycles -> all outputs 0, Run=0. First cycle after release is RST, then T0 with PCout=MARin=IncPC=Zin=1, Run=1.
- mflo: IR=32'hC8800000 (op 11001) -> T3 drives LOout=Gra=Rin=1 for exactly one cycle, then returns to T0. Total 4 cycles per instruction.
- add: IR=32'h18000000 (op 00011) -> T3 Grb/Rout/Yin, T4 Grc/Rout/Zin with ALUop=0, T5 Zlowout/Gra/Rin, then T0. Bus-driver one-hot check passes every cycle.
- mul: IR=32'h70000000 (op 01110) -> T4 ALUop=4, T5 Zlowout+LOin, T6 Zhighout+HIin. 7 cycles total.
- Stop and halt:
  - Stop=1 during T5 of an add -> HALT next cycle, Run=0, held for 10 cycles.
  - IR=32'hD8000000 (halt) -> HALT after T3 even with Stop=0.
- Reset mid-operation: assert Reset during T4 of a div -> next cycle RST with all strobes 0. After release, fetch restarts at T0.

Source files
------------

// File: rtl/control_sequencer.sv
// Hardwired Moore fetch/decode/execute sequencer that drives the Datapath strobes; outputs decode state and IR[31:27].
// Latency: 3 fetch steps plus 1-4 execute steps per instruction; no backpressure, Stop is only sampled on the last step.
module control_sequencer (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [31:0] IR,
    input  logic        Stop,
    output logic        Run,
    output logic        PCout,
    output logic        Zlowout,
    output logic        Zhighout,
    output logic        MDRout,
    output logic        HIout,
    output logic        LOout,
    output logic        Cout,
    output logic        BAout,
    output logic        Rout,
    output logic        MARin,
    output logic        Zin,
    output logic        PCin,
    output logic        MDRin,
    output logic        IRin,
    output logic        Yin,
    output logic        LOin,
    output logic        HIin,
    output logic        Rin,
    output logic        CONin,
    output logic        IncPC,
    output logic        Read,
    output logic        Write,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic [3:0]  ALUop
);
    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_MUL = 4'd4;
    localparam logic [3:0] ALU_DIV = 4'd5;

    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_MUL  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_MFHI = 5'b11000;
    localparam logic [4:0] OP_MFLO = 5'b11001;
    localparam logic [4:0] OP_HALT = 5'b11011;

    typedef enum logic [3:0] {
        S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
    } state_t;

    state_t     r_state;
    logic [4:0] w_op;
    logic       w_is_alu;
    logic       w_is_md;
    logic       w_is_ldi;
    logic       w_unused_ir;

    assign w_op        = IR[31:27];
    assign w_unused_ir = ^IR[26:0];
    assign w_is_alu    = (w_op == OP_ADD) || (w_op == OP_SUB) || (w_op == OP_AND) || (w_op == OP_OR);
    assign w_is_md     = (w_op == OP_MUL) || (w_op == OP_DIV);
    assign w_is_ldi    = (w_op == OP_LDI);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state <= S_RST;
        end else begin
            case (r_state)
                S_RST:  r_state <= S_T0;
                S_T0:   r_state <= S_T1;
                S_T1:   r_state <= S_T2;
                S_T2:   r_state <= S_T3;
                S_T3: begin
                    if (w_op == OP_HALT)                      r_state <= S_HALT;
                    else if (w_is_alu || w_is_md || w_is_ldi) r_state <= S_T4;
                    else                                      r_state <= Stop ? S_HALT : S_T0;
                end
                S_T4:   r_state <= S_T5;
                S_T5: begin
                    if (w_is_md) r_state <= S_T6;
                    else         r_state <= Stop ? S_HALT : S_T0;
                end
                S_T6:   r_state <= Stop ? S_HALT : S_T0;
                S_HALT: r_state <= S_HALT;
                default: r_state <= S_RST;
            endcase
        end
    end

    always_comb begin
        Run = (r_state != S_RST) && (r_state != S_HALT);
        PCout = 1'b0; Zlowout = 1'b0; Zhighout = 1'b0; MDRout = 1'b0; HIout = 1'b0;
        LOout = 1'b0; Cout = 1'b0; BAout = 1'b0; Rout = 1'b0;
        MARin = 1'b0; Zin = 1'b0; PCin = 1'b0; MDRin = 1'b0; IRin = 1'b0;
        Yin = 1'b0; LOin = 1'b0; HIin = 1'b0; Rin = 1'b0; CONin = 1'b0;
        IncPC = 1'b0; Read = 1'b0; Write = 1'b0;
        Gra = 1'b0; Grb = 1'b0; Grc = 1'b0;
        ALUop = ALU_ADD;
        case (r_state)
            S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
            S_T1: begin Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
            S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
            S_T3: begin
                if (w_is_alu)             begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                else if (w_is_md)         begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                else if (w_is_ldi)        begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
                else if (w_op == OP_MFHI) begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                else if (w_op == OP_MFLO) begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            end
            S_T4: begin
                Zin = 1'b1;
                if (w_is_ldi)     Cout = 1'b1;
                else              Rout = 1'b1;
                if (w_is_alu)     Grc = 1'b1;
                else if (w_is_md) Grb = 1'b1;
                case (w_op)
                    OP_SUB:  ALUop = ALU_SUB;
                    OP_AND:  ALUop = ALU_AND;
                    OP_OR:   ALUop = ALU_OR;
                    OP_MUL:  ALUop = ALU_MUL;
                    OP_DIV:  ALUop = ALU_DIV;
                    default: ALUop = ALU_ADD;
                endcase
            end
            S_T5: begin
                Zlowout = 1'b1;
                if (w_is_md) LOin = 1'b1;
                else begin Gra = 1'b1; Rin = 1'b1; end
            end
            S_T6: begin Zhighout = 1'b1; HIin = 1'b1; end
            default: ;
        endcase
    end
endmodule
